key_step_gen: RTL and testbench
===============================

KEY_STEP_GEN -- requirements
Module: key_step_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable synchronized samples required to accept a level change (legal range 2..65535).
REQ-002 Parameter REPEAT_DELAY, default 10, is the number of cycles from the press step to the first auto-repeat step (legal range 2..65535).
REQ-003 Parameter REPEAT_PERIOD, default 5, is the number of cycles between consecutive auto-repeat steps (legal range 2..65535).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 key_in  input  1  raw pushbutton, active-high pressed, asynchronous to clk, may bounce.
REQ-007 key_level  output  1  registered debounced key state.
REQ-008 step  output  1  registered single-cycle advance strobe for the downstream LFSR stage.
REQ-009 step_cnt  output  8  registered count of step pulses issued, modulo 256.

Function
REQ-010 key_in SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-011 Debounce counter SHALL be 16 bits wide; it increments each cycle sync2 != key_level and clears to 0 on any cycle sync2 == key_level.
REQ-012 When the counter equals DEBOUNCE_CYCLES-1 and sync2 != key_level, key_level SHALL take sync2 on that edge and the counter SHALL clear.
REQ-013 Latency: a clean key_in rise is reflected on key_level exactly 2+DEBOUNCE_CYCLES rising edges after the first edge sampling it high.
REQ-014 Any bounce (sync2 returning to key_level) before the threshold SHALL restart the count; no key_level change, no step.
REQ-015 Control FSM states: IDLE (key released), HELD (pressed, waiting REPEAT_DELAY), REPEAT (pressed, periodic steps).
REQ-016 IDLE -> HELD on the edge key_level goes 0->1; step SHALL be 1 in the cycle key_level first reads 1.
REQ-017 HELD -> REPEAT when 16-bit repeat timer reaches REPEAT_DELAY-1 with key_level still 1; step pulses 1 cycle on that transition edge and timer clears.
REQ-018 In REPEAT, step pulses 1 cycle each time timer reaches REPEAT_PERIOD-1, then timer clears.
REQ-019 Any state -> IDLE on the edge key_level goes 1->0; no step on release; timer clears.
REQ-020 step SHALL never be high on two consecutive cycles.
REQ-021 step_cnt SHALL increment by 1 on every edge where step is asserted, wrapping 255 -> 0.
REQ-022 Release and a timer expiry in the same cycle: release wins, no step.

Reset
REQ-023 rst_n low SHALL asynchronously force sync1, sync2, key_level, step = 0, step_cnt = 0, both counters = 0, FSM = IDLE.
REQ-024 Reset deassertion with key_in held high SHALL produce a normal debounced press (one step after 2+DEBOUNCE_CYCLES edges); reset mid-repeat SHALL discard all pending steps.

Configuration
REQ-025 Macro KEY_STEP_GEN_AUTO_REPEAT_EN defined: HELD/REPEAT behaviour per REQ-017/018.
REQ-026 Macro undefined: repeat timer and REPEAT state SHALL not be built; exactly one step per debounced press; HELD remains until release; REPEAT_DELAY/REPEAT_PERIOD ignored.

Verification
REQ-027 Clean press, defaults, macro undefined: key_in 0->1 held 50 cycles -> key_level high at edge 6, step high 1 cycle at edge 6, step_cnt=1, no further steps.
REQ-028 Bounce: key_in toggles 1,0,1,0 each cycle then held 1 -> no step during toggling; single step 6 edges after final rise; step_cnt=1.
REQ-029 Auto-repeat, macro defined, held 30 cycles after press step -> steps at +0, +10, +15, +20, +25 relative to press step; step_cnt=5.
REQ-030 Release: key_in 1->0 after press -> key_level low 6 edges later, FSM IDLE, no step; release coincident with repeat expiry -> no step.
REQ-031 Wrap: 256 debounced presses -> step_cnt returns to 0, 257th press -> 1.
REQ-032 Async reset asserted mid-REPEAT between clock edges -> all outputs 0 immediately; after release with key_in high, first step after 6 edges.

Source files
------------

// File: rtl/key_step_gen.sv
// Debounced pushbutton to single-cycle step strobe, with optional auto-repeat (KEY_STEP_GEN_AUTO_REPEAT_EN).
// Latency: key_in edge to key_level/step is 2+DEBOUNCE_CYCLES clocks; no backpressure, step is a fire-and-forget strobe.
module key_step_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 10,
    parameter int unsigned REPEAT_PERIOD   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_in,
    output logic       key_level,
    output logic       step,
    output logic [7:0] step_cnt
);

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 ||
        REPEAT_DELAY < 2 || REPEAT_DELAY > 65535 ||
        REPEAT_PERIOD < 2 || REPEAT_PERIOD > 65535) begin : g_bad_param
        $error("key_step_gen: parameter out of range 2..65535");
    end

`ifdef KEY_STEP_GEN_AUTO_REPEAT_EN
    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;
    localparam logic [15:0] RD_LAST = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] RP_LAST = 16'(REPEAT_PERIOD - 1);
    logic [15:0] timer, timer_nxt;
`else
    typedef enum logic [1:0] {IDLE, HELD} state_t;
`endif

    state_t      state, state_nxt;
    logic        sync1, sync2;
    logic [15:0] db_cnt;
    logic        accept, rise, fall;
    logic        step_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    // A level change is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
    assign accept = (sync2 != key_level) && (db_cnt == DB_LAST);
    assign rise   = accept && sync2;
    assign fall   = accept && !sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt    <= 16'd0;
            key_level <= 1'b0;
        end else if (sync2 == key_level) begin
            db_cnt <= 16'd0;
        end else if (accept) begin
            db_cnt    <= 16'd0;
            key_level <= sync2;
        end else begin
            db_cnt <= db_cnt + 16'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = 1'b0;
`ifdef KEY_STEP_GEN_AUTO_REPEAT_EN
        timer_nxt = 16'd0;
`endif
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = HELD;
                    step_nxt  = 1'b1;
                end
            end
            HELD: begin
                if (fall) begin
                    state_nxt = IDLE;
`ifdef KEY_STEP_GEN_AUTO_REPEAT_EN
                end else if (timer == RD_LAST) begin
                    state_nxt = REPEAT;
                    step_nxt  = 1'b1;
                end else begin
                    timer_nxt = timer + 16'd1;
`endif
                end
            end
`ifdef KEY_STEP_GEN_AUTO_REPEAT_EN
            REPEAT: begin
                // Release takes priority over a coincident period expiry.
                if (fall) begin
                    state_nxt = IDLE;
                end else if (timer == RP_LAST) begin
                    step_nxt = 1'b1;
                end else begin
                    timer_nxt = timer + 16'd1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            step     <= 1'b0;
            step_cnt <= 8'd0;
`ifdef KEY_STEP_GEN_AUTO_REPEAT_EN
            timer    <= 16'd0;
`endif
        end else begin
            state    <= state_nxt;
            step     <= step_nxt;
            step_cnt <= step_cnt + {7'd0, step_nxt};
`ifdef KEY_STEP_GEN_AUTO_REPEAT_EN
            timer    <= timer_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_key_step_gen.sv
// Randomized and directed bench for key_step_gen against a sample-run-length behavioural model.
module tb_key_step_gen;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 5;
`ifdef KEY_STEP_GEN_AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_in = 1'b0;
    logic       key_level;
    logic       step;
    logic [7:0] step_cnt;

    int vectors = 0;
    int miscompares = 0;

    key_step_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .key_level(key_level),
        .step     (step),
        .step_cnt (step_cnt)
    );

    always #5 clk = ~clk;

    // Model: key_level flips after D consecutive synchronized samples disagree with it;
    // steps occur at press and, with auto-repeat, at RD + n*RP cycles after the press.
    logic m_s1, m_s2, m_lvl, m_step;
    int   m_run, m_since, m_cnt;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_step = 0;
        m_run = 0; m_since = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic k);
        logic old_s2;
        bit   changed;
        old_s2  = m_s2;
        m_s2    = m_s1;
        m_s1    = k;
        m_step  = 0;
        changed = 0;
        if (old_s2 != m_lvl) begin
            m_run++;
            if (m_run == D) begin
                m_lvl   = old_s2;
                m_run   = 0;
                changed = 1;
            end
        end else begin
            m_run = 0;
        end
        if (changed && m_lvl) begin
            m_since = 0;
            m_step  = 1;
        end else if (!changed && m_lvl) begin
            m_since++;
            if (AUTO && m_since >= RD && (m_since - RD) % RP == 0) m_step = 1;
        end
        m_cnt = (m_cnt + int'(m_step)) % 256;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else model_step(key_in);
        #1;
        chk("model.key_level", int'(key_level), int'(m_lvl));
        chk("model.step", int'(step), int'(m_step));
        chk("model.step_cnt", int'(step_cnt), m_cnt);
    end

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic cyc(input logic k);
        @(negedge clk);
        key_in = k;
        after_edge();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        key_in = 1'b0;
        repeat (3) after_edge();
        chk("reset.key_level", int'(key_level), 0);
        chk("reset.step", int'(step), 0);
        chk("reset.step_cnt", int'(step_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int nsteps;

    initial begin
        do_reset();

        // Clean press: level and step at the 6th edge sampling key_in high.
        for (int e = 1; e <= 6; e++) begin
            cyc(1'b1);
            if (e < 6) chk("press.level_early", int'(key_level), 0);
        end
        chk("press.level", int'(key_level), 1);
        chk("press.step", int'(step), 1);
        chk("press.step_cnt", int'(step_cnt), 1);
        cyc(1'b1);
        chk("press.step_single", int'(step), 0);
        nsteps = 1;
        for (int e = 2; e <= 29; e++) begin
            cyc(1'b1);
            nsteps += int'(step);
        end
        chk("hold.steps", nsteps, AUTO ? 5 : 1);
        chk("hold.step_cnt", int'(step_cnt), AUTO ? 5 : 1);
        cyc(1'b1);
        for (int e = 1; e <= 6; e++) begin
            cyc(1'b0);
            if (e == 5) chk("release.level_early", int'(key_level), 1);
        end
        chk("release.level", int'(key_level), 0);
        chk("release.step", int'(step), 0);

        // Bounce then settle high: single step 6 edges after final rise.
        do_reset();
        cyc(1'b1); cyc(1'b0); cyc(1'b1); cyc(1'b0);
        chk("bounce.step_cnt", int'(step_cnt), 0);
        for (int e = 1; e <= 6; e++) begin
            cyc(1'b1);
            if (e < 6) chk("bounce.level_early", int'(key_level), 0);
        end
        chk("bounce.step", int'(step), 1);
        chk("bounce.step_cnt", int'(step_cnt), 1);

        // Release landing exactly on the first repeat expiry (press step + 15).
        do_reset();
        repeat (6) cyc(1'b1);
        repeat (9) cyc(1'b1);
        for (int e = 10; e <= 15; e++) cyc(1'b0);
        chk("coincide.level", int'(key_level), 0);
        chk("coincide.step", int'(step), 0);
        chk("coincide.step_cnt", int'(step_cnt), AUTO ? 2 : 1);

        // Counter wrap over 257 presses.
        do_reset();
        for (int p = 1; p <= 257; p++) begin
            repeat (8) cyc(1'b1);
            repeat (8) cyc(1'b0);
            if (p == 256) chk("wrap.256", int'(step_cnt), 0);
        end
        chk("wrap.257", int'(step_cnt), 1);

        // Async reset in mid-repeat, then a press straight out of reset.
        repeat (6) cyc(1'b1);
        repeat (20) cyc(1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async.key_level", int'(key_level), 0);
        chk("async.step", int'(step), 0);
        chk("async.step_cnt", int'(step_cnt), 0);
        repeat (2) after_edge();
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            after_edge();
            if (e < 6) chk("rst_press.step_early", int'(step), 0);
        end
        chk("rst_press.step", int'(step), 1);
        chk("rst_press.step_cnt", int'(step_cnt), 1);

        // Random segments: mix of short bounces and long holds.
        for (int s = 0; s < 150; s++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                             : int'($urandom_range(5, 40));
            repeat (len) cyc(lvl);
        end

        repeat (2) after_edge();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
